// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for a five-stage pipeline. It handles load-use stalls,
// taken-branch flushes and data-memory wait states, and latches an error if memory never completes.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_WR,
   input  logic             EX_branch_taken,
   input  logic             M_MemRead,
   input  logic             M_MemWrite,
   input  logic             DM_ready,
   output logic             PCWrite,
   output logic             IF_IDWrite,
   output logic             ID_EXWrite,
   output logic             EX_MWrite,
   output logic             M_WBWrite,
   output logic             IF_ID_flush,
   output logic             ID_EX_flush,
   output logic             M_WB_bubble,
   output logic [CNT_W-1:0] stall_count,
   output logic             timeout_err
);

   // state      | meaning
   // S_RUN      | normal issue, resolves load-use / branch / memory hazards
   // S_MEM_WAIT | data memory access outstanding, pipeline frozen except M_WB bubble
   // S_ERR      | memory timed out, everything frozen until reset
   typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERR} state_t;

   localparam int WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] TO_VAL = WC_W'(MEM_TIMEOUT);
   // With a timeout of 1 the first wait cycle already exhausts the budget.
   localparam logic TO_FIRST = (MEM_TIMEOUT <= 1);

   state_t          state, state_nxt;
   logic [WC_W-1:0] wait_cnt, wait_cnt_nxt, wait_inc;
   logic            mem_busy, load_use;

   assign mem_busy = (M_MemRead | M_MemWrite) & ~DM_ready;
   assign load_use = EX_MemRead & (EX_WR != 5'd0) & ((EX_WR == ID_rs) | (EX_WR == ID_rt));
   assign wait_inc = wait_cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_RUN;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
         stall_count <= '0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         timeout_err <= timeout_err | (state_nxt == S_ERR);
         if (!PCWrite && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         S_RUN: begin
            wait_cnt_nxt = '0;
            if (mem_busy) begin
               wait_cnt_nxt = WC_W'(1);
               state_nxt    = TO_FIRST ? S_ERR : S_MEM_WAIT;
            end
         end
         S_MEM_WAIT: begin
            if (DM_ready) begin
               wait_cnt_nxt = '0;
               state_nxt    = S_RUN;
            end else begin
               wait_cnt_nxt = wait_inc;
               if (wait_inc == TO_VAL)
                  state_nxt = S_ERR;
            end
         end
         S_ERR:   state_nxt = S_ERR;
         default: state_nxt = S_RUN;
      endcase
   end

   always_comb begin
      PCWrite     = 1'b0;
      IF_IDWrite  = 1'b0;
      ID_EXWrite  = 1'b0;
      EX_MWrite   = 1'b0;
      M_WBWrite   = 1'b0;
      IF_ID_flush = 1'b0;
      ID_EX_flush = 1'b0;
      M_WB_bubble = 1'b0;
      if (state != S_ERR) begin
         if ((state == S_MEM_WAIT) ? ~DM_ready : mem_busy) begin
            M_WBWrite   = 1'b1;
            M_WB_bubble = 1'b1;
         end else if (load_use) begin
            ID_EXWrite  = 1'b1;
            ID_EX_flush = 1'b1;
            EX_MWrite   = 1'b1;
            M_WBWrite   = 1'b1;
         end else begin
            PCWrite     = 1'b1;
            IF_IDWrite  = 1'b1;
            ID_EXWrite  = 1'b1;
            EX_MWrite   = 1'b1;
            M_WBWrite   = 1'b1;
            IF_ID_flush = EX_branch_taken;
            ID_EX_flush = EX_branch_taken;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, all checked
// against a cycle-level model of the hazard rules (second instance uses a 4-bit stall counter).
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_wr = '0;
   logic ex_memread = 0, ex_br = 0, m_rd = 0, m_wr = 0, dm_rdy = 0;

   logic pcw, ifidw, idexw, exmw, mwbw, ifflush, idflush, bubble, terr;
   logic pcw2, ifidw2, idexw2, exmw2, mwbw2, ifflush2, idflush2, bubble2, terr2;
   logic [15:0] stall;
   logic [3:0]  stall2;
   logic [7:0]  outs;

   int n_err = 0, n_chk = 0;
   int m_err, m_wait, m_wcnt, m_stalls, m_terr;
   localparam int TO = 15;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .ID_rs(id_rs), .ID_rt(id_rt), .EX_MemRead(ex_memread),
      .EX_WR(ex_wr), .EX_branch_taken(ex_br), .M_MemRead(m_rd), .M_MemWrite(m_wr),
      .DM_ready(dm_rdy), .PCWrite(pcw), .IF_IDWrite(ifidw), .ID_EXWrite(idexw),
      .EX_MWrite(exmw), .M_WBWrite(mwbw), .IF_ID_flush(ifflush), .ID_EX_flush(idflush),
      .M_WB_bubble(bubble), .stall_count(stall), .timeout_err(terr));

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .ID_rs(id_rs), .ID_rt(id_rt), .EX_MemRead(ex_memread),
      .EX_WR(ex_wr), .EX_branch_taken(ex_br), .M_MemRead(m_rd), .M_MemWrite(m_wr),
      .DM_ready(dm_rdy), .PCWrite(pcw2), .IF_IDWrite(ifidw2), .ID_EXWrite(idexw2),
      .EX_MWrite(exmw2), .M_WBWrite(mwbw2), .IF_ID_flush(ifflush2), .ID_EX_flush(idflush2),
      .M_WB_bubble(bubble2), .stall_count(stall2), .timeout_err(terr2));

   assign outs = {pcw, ifidw, idexw, exmw, mwbw, ifflush, idflush, bubble};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected outputs {PCW,IFIDW,IDEXW,EXMW,MWBW,IF_flush,ID_flush,bubble} from the hazard rules.
   function automatic logic [7:0] model_out();
      bit busy, lu, frozen;
      busy = (m_rd || m_wr) && !dm_rdy;
      lu   = ex_memread && ex_wr != 0 && (ex_wr == id_rs || ex_wr == id_rt);
      frozen = m_wait ? !dm_rdy : busy;
      if (m_err)       return 8'b00000000;
      if (frozen)      return 8'b00001001;
      if (lu)          return 8'b00111010;
      if (ex_br)       return 8'b11111110;
      return 8'b11111000;
   endfunction

   task automatic model_edge(input bit pc_en);
      bit busy;
      busy = (m_rd || m_wr) && !dm_rdy;
      if (!pc_en) m_stalls++;
      if (m_err) return;
      if (m_wait) begin
         if (dm_rdy) m_wait = 0;
         else begin
            m_wcnt++;
            if (m_wcnt >= TO) begin m_err = 1; m_terr = 1; m_wait = 0; end
         end
      end else if (busy) begin
         m_wcnt = 1;
         if (m_wcnt >= TO) begin m_err = 1; m_terr = 1; end
         else m_wait = 1;
      end
   endtask

   task automatic idle_inputs();
      id_rs = 0; id_rt = 0; ex_wr = 0; ex_memread = 0; ex_br = 0;
      m_rd = 0; m_wr = 0; dm_rdy = 0;
   endtask

   // Called in the low clock phase with inputs already driven; returns at the next falling edge.
   task automatic step();
      logic [7:0] exp;
      #1;
      exp = model_out();
      check("outs", {24'd0, outs}, {24'd0, exp});
      check("outs_w4", {24'd0, pcw2, ifidw2, idexw2, exmw2, mwbw2, ifflush2, idflush2, bubble2},
            {24'd0, exp});
      @(posedge clk);
      model_edge(exp[7]);
      #1;
      check("stall_count", {16'd0, stall}, (m_stalls > 65535) ? 65535 : m_stalls);
      check("stall_count_w4", {28'd0, stall2}, (m_stalls > 15) ? 15 : m_stalls);
      check("timeout_err", {31'd0, terr}, m_terr);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      m_err = 0; m_wait = 0; m_wcnt = 0; m_stalls = 0; m_terr = 0;
      check("rst_stall", {16'd0, stall}, 0);
      check("rst_terr", {31'd0, terr}, 0);
      idle_inputs();
      #1;
      check("rst_outs", {24'd0, outs}, 32'hF8);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int burst;
      idle_inputs();
      @(negedge clk);
      do_reset();

      // Load-use on rs: one stall cycle.
      ex_memread = 1; ex_wr = 5; id_rs = 5;
      step();
      check("r31_stall", {16'd0, stall}, 1);
      idle_inputs(); step();

      // Load to r0 is never a hazard.
      ex_memread = 1; ex_wr = 0; id_rs = 0; id_rt = 0;
      #1 check("r32_outs", {24'd0, outs}, 32'hF8);
      step();

      // Memory wait of three cycles.
      do_reset();
      m_rd = 1; dm_rdy = 0;
      repeat (3) step();
      dm_rdy = 1;
      #1 check("r33_ready_outs", {24'd0, outs}, 32'hF8);
      step();
      check("r33_stall", {16'd0, stall}, 3);
      idle_inputs(); step();

      // Memory timeout into ERR, then reset recovery.
      do_reset();
      m_wr = 1; dm_rdy = 0;
      repeat (TO) step();
      check("r34_terr", {31'd0, terr}, 1);
      #1 check("r34_err_outs", {24'd0, outs}, 0);
      step(); step();
      do_reset();
      check("r34_post_rst_terr", {31'd0, terr}, 0);

      // Load-use has priority over taken branch; branch alone flushes.
      ex_memread = 1; ex_wr = 7; id_rt = 7; ex_br = 1;
      #1 check("r35_lu_br", {24'd0, outs}, 32'h3A);
      step();
      ex_memread = 0;
      #1 check("r35_br", {24'd0, outs}, 32'hFE);
      step();

      // Ready memory access costs nothing.
      m_rd = 1; dm_rdy = 1; ex_br = 0;
      step();

      // Saturation of the narrow counter.
      do_reset();
      ex_memread = 1; ex_wr = 3; id_rs = 3;
      repeat (20) step();
      check("r36_sat4", {28'd0, stall2}, 15);
      check("r36_wide", {16'd0, stall}, 20);

      // Asynchronous reset while waiting on memory.
      do_reset();
      m_rd = 1; dm_rdy = 0;
      repeat (3) step();
      do_reset();

      // Random traffic with occasional long memory stalls.
      burst = 0;
      for (int i = 0; i < 1500; i++) begin
         id_rs = 5'($urandom_range(0, 3));
         id_rt = 5'($urandom_range(0, 3));
         ex_wr = 5'($urandom_range(0, 3));
         ex_memread = ($urandom_range(0, 2) == 0);
         ex_br = ($urandom_range(0, 3) == 0);
         m_rd = ($urandom_range(0, 2) == 0);
         m_wr = ($urandom_range(0, 5) == 0);
         if (burst > 0) begin
            dm_rdy = 0; burst--;
         end else if ($urandom_range(0, 9) == 0) begin
            burst = $urandom_range(1, 18); dm_rdy = 0;
         end else begin
            dm_rdy = ($urandom_range(0, 2) != 0);
         end
         step();
         if (m_err != 0 && $urandom_range(0, 3) == 0) begin
            do_reset();
            burst = 0;
         end else if ($urandom_range(0, 199) == 0) begin
            do_reset();
            burst = 0;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      n_err++;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max wait cycles for a data-memory access before error.
REQ-002 Parameter CNT_W, default 16: width of stall_count.
REQ-003 clk  input  1  clock; state updates on rising edge; pipeline registers sample outputs on falling edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ID_rs, ID_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 EX_MemRead  input  1  instruction in EX is a load.
REQ-007 EX_WR  input  5  destination register of the instruction in EX.
REQ-008 EX_branch_taken  input  1  branch/jump in EX resolved taken.
REQ-009 M_MemRead, M_MemWrite  input  1 each  instruction in M accesses data memory.
REQ-010 DM_ready  input  1  data memory completes the current access this cycle.
REQ-011 PCWrite, IF_IDWrite, ID_EXWrite, EX_MWrite, M_WBWrite  output  1 each  pipeline register write enables.
REQ-012 IF_ID_flush, ID_EX_flush  output  1 each  load zeros/NOP into that register on its next write.
REQ-013 M_WB_bubble  output  1  M_WB loads RegWrite=0, MemtoReg=0 on its next write.
REQ-014 stall_count  output  CNT_W  cycles with PCWrite=0 since reset.
REQ-015 timeout_err  output  1  sticky memory timeout flag.

Function
REQ-016 The block SHALL have three states: RUN, MEM_WAIT, ERR. Outputs are combinational from state and inputs; state, wait counter, stall_count and timeout_err are registered.
REQ-017 The mem_busy condition SHALL be (M_MemRead|M_MemWrite) & !DM_ready.
REQ-018 The load_use condition SHALL be EX_MemRead & EX_WR!=0 & (EX_WR==ID_rs | EX_WR==ID_rt).
REQ-019 RUN, no condition: all five enables=1; flush/bubble outputs=0.
REQ-020 RUN with mem_busy: all enables=0 except M_WBWrite=1 with M_WB_bubble=1; next state MEM_WAIT; wait counter loads 1.
REQ-021 MEM_WAIT with !DM_ready: same outputs as REQ-020; wait counter increments; when counter==MEM_TIMEOUT, next state ERR and timeout_err set.
REQ-022 MEM_WAIT with DM_ready: all enables=1, flush/bubble=0; next state RUN; load_use and branch are re-evaluated in that cycle with RUN priority rules.
REQ-023 RUN, load_use, not mem_busy: PCWrite=0, IF_IDWrite=0, ID_EXWrite=1 with ID_EX_flush=1, EX_MWrite=1, M_WBWrite=1; state stays RUN (hazard clears next cycle as EX holds the bubble).
REQ-024 RUN, EX_branch_taken, not mem_busy: all enables=1, IF_ID_flush=1, ID_EX_flush=1.
REQ-025 Priority SHALL be mem_busy > load_use > EX_branch_taken; when load_use and branch both hold, load_use outputs apply.
REQ-026 ERR: all enables=0, flush/bubble=0; state held until reset; timeout_err stays 1.
REQ-027 stall_count SHALL increment by 1 each rising edge where PCWrite=0 and saturate at all-ones.
REQ-028 An access in M whose DM_ready is already 1 SHALL cause no stall.

Reset
REQ-029 While rst=1: state=RUN, wait counter=0, stall_count=0, timeout_err=0; outputs follow RUN with no condition only when inputs are idle.
REQ-030 rst asserted mid-MEM_WAIT or in ERR SHALL return to RUN immediately, without waiting for a clock edge.

Verification
REQ-031 EX_MemRead=1, EX_WR=5, ID_rs=5 for 1 cycle -> PCWrite=0, IF_IDWrite=0, ID_EX_flush=1 that cycle; stall_count=1.
REQ-032 EX_MemRead=1, EX_WR=0, ID_rs=0 -> no stall, all enables=1.
REQ-033 M_MemRead=1, DM_ready low 3 cycles then high -> 3 cycles of enables=0 with M_WB_bubble=1, then all enables=1; stall_count=3; state RUN.
REQ-034 M_MemWrite=1, DM_ready held low, MEM_TIMEOUT=15 -> ERR after 15th wait cycle, timeout_err=1, all enables=0; rst pulse -> RUN, timeout_err=0, stall_count=0.
REQ-035 EX_branch_taken=1 together with load_use -> load_use outputs (REQ-023), no IF_ID_flush; EX_branch_taken=1 alone -> IF_ID_flush=ID_EX_flush=1, PCWrite=1.
REQ-036 CNT_W=4, 20 stall cycles -> stall_count saturates at 15.
